// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared IF/ID types and constants
package pipeline_pkg;

  localparam int          INST_W   = 16;
  localparam int          PC_W     = 32;
  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic {
    S_NORM = 1'b0,
    S_IMM  = 1'b1
  } fsm_state_t;

  // One decode packet, so the decode stage can consume a single bundle.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] imm;
    logic [PC_W-1:0]   pc;
    logic              valid;
    logic              imm_valid;
  } if_id_t;

endpackage

// File: rtl/fetch_decode_buffer.sv
// rtl/fetch_decode_buffer.sv - IF/ID register that reassembles opcode+immediate pairs
module fetch_decode_buffer #(
  parameter int          TWO_WORD_BIT = 15,
  parameter logic [15:0] NOP_WORD     = 16'h0000,
  parameter int          PC_W         = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     instruction,
  input  logic [PC_W-1:0] pc_in,
  input  logic            stall,
  input  logic            flush,
  output logic [15:0]     inst_out,
  output logic [15:0]     imm_out,
  output logic [PC_W-1:0] pc_out,
  output logic            valid_out,
  output logic            imm_valid
);

  import pipeline_pkg::fsm_state_t;
  import pipeline_pkg::S_NORM;
  import pipeline_pkg::S_IMM;

  fsm_state_t      state_q, state_d;
  logic [15:0]     inst_q, inst_d;
  logic [15:0]     imm_q, imm_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            imm_valid_q, imm_valid_d;
  logic [15:0]     hold_inst_q, hold_inst_d;
  logic [PC_W-1:0] hold_pc_q, hold_pc_d;

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    imm_valid_d = imm_valid_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;

    if (flush) begin
      // pc_d keeps its old value: the PC is meaningless on a squashed slot.
      state_d     = S_NORM;
      inst_d      = NOP_WORD;
      imm_d       = 16'h0000;
      valid_d     = 1'b0;
      imm_valid_d = 1'b0;
      hold_inst_d = 16'h0000;
      hold_pc_d   = '0;
    end else if (!stall) begin
      case (state_q)
        S_NORM: begin
          if (instruction[TWO_WORD_BIT]) begin
            hold_inst_d = instruction;
            hold_pc_d   = pc_in;
            inst_d      = NOP_WORD;
            imm_d       = 16'h0000;
            valid_d     = 1'b0;
            imm_valid_d = 1'b0;
            state_d     = S_IMM;
          end else begin
            inst_d      = instruction;
            pc_d        = pc_in;
            imm_d       = 16'h0000;
            valid_d     = 1'b1;
            imm_valid_d = 1'b0;
          end
        end
        S_IMM: begin
          // The immediate word is raw data; its top bit is never decoded.
          inst_d      = hold_inst_q;
          pc_d        = hold_pc_q;
          imm_d       = instruction;
          valid_d     = 1'b1;
          imm_valid_d = 1'b1;
          state_d     = S_NORM;
        end
        default: state_d = S_NORM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_NORM;
      inst_q      <= NOP_WORD;
      imm_q       <= 16'h0000;
      pc_q        <= '0;
      valid_q     <= 1'b0;
      imm_valid_q <= 1'b0;
      hold_inst_q <= 16'h0000;
      hold_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      imm_valid_q <= imm_valid_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
    end
  end

  assign inst_out  = inst_q;
  assign imm_out   = imm_q;
  assign pc_out    = pc_q;
  assign valid_out = valid_q;
  assign imm_valid = imm_valid_q;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// tb/tb_fetch_decode_buffer.sv - directed vectors with a scoreboard monitor
module tb_fetch_decode_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic [31:0] pc_in;
  logic        stall;
  logic        flush;
  logic [15:0] inst_out;
  logic [15:0] imm_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        imm_valid;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        fls;
    logic [15:0] ins;
    logic [31:0] pc;
    logic        ev;
    logic        eiv;
    logic [15:0] einst;
    logic [15:0] eimm;
    logic [31:0] epc;
    logic        cpc;
    int          id;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  fetch_decode_buffer #(
    .TWO_WORD_BIT(15),
    .NOP_WORD    (16'h0000),
    .PC_W        (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instruction(instruction),
    .pc_in      (pc_in),
    .stall      (stall),
    .flush      (flush),
    .inst_out   (inst_out),
    .imm_out    (imm_out),
    .pc_out     (pc_out),
    .valid_out  (valid_out),
    .imm_valid  (imm_valid)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic stl, input logic fls,
                              input logic [15:0] ins, input logic [31:0] pc,
                              input logic ev, input logic eiv, input logic [15:0] einst,
                              input logic [15:0] eimm, input logic [31:0] epc,
                              input logic cpc);
    vec_t v;
    v.rst = rst; v.stl = stl; v.fls = fls; v.ins = ins; v.pc = pc;
    v.ev = ev; v.eiv = eiv; v.einst = einst; v.eimm = eimm; v.epc = epc; v.cpc = cpc;
    v.id = 0;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  // Monitor: every output slot after a driven edge is compared to the scoreboard head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      chk("valid_out", e.id, {31'd0, valid_out}, {31'd0, e.ev});
      chk("imm_valid", e.id, {31'd0, imm_valid}, {31'd0, e.eiv});
      chk("inst_out", e.id, {16'd0, inst_out}, {16'd0, e.einst});
      chk("imm_out", e.id, {16'd0, imm_out}, {16'd0, e.eimm});
      if (e.cpc) chk("pc_out", e.id, pc_out, e.epc);
    end
  end

  initial begin
    //            rst  stl  fls  instr     pc      v    iv   inst      imm       epc  cpc
    vecs.push_back(mk(1, 0, 0, 16'h0000, 32'd0,   0, 0, 16'h0000, 16'h0000, 32'd0,   1));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 32'd0,   0, 0, 16'h0000, 16'h0000, 32'd0,   1));
    vecs.push_back(mk(0, 0, 0, 16'h1234, 32'd50,  1, 0, 16'h1234, 16'h0000, 32'd50,  1));
    vecs.push_back(mk(0, 0, 0, 16'h8A01, 32'd51,  0, 0, 16'h0000, 16'h0000, 32'd0,   0));
    vecs.push_back(mk(0, 0, 0, 16'hBEEF, 32'd52,  1, 1, 16'h8A01, 16'hBEEF, 32'd51,  1));
    vecs.push_back(mk(0, 0, 0, 16'h0042, 32'd60,  1, 0, 16'h0042, 16'h0000, 32'd60,  1));
    vecs.push_back(mk(0, 1, 0, 16'h0077, 32'd61,  1, 0, 16'h0042, 16'h0000, 32'd60,  1));
    vecs.push_back(mk(0, 1, 0, 16'h0077, 32'd61,  1, 0, 16'h0042, 16'h0000, 32'd60,  1));
    vecs.push_back(mk(0, 1, 0, 16'h0077, 32'd61,  1, 0, 16'h0042, 16'h0000, 32'd60,  1));
    vecs.push_back(mk(0, 0, 0, 16'h0077, 32'd61,  1, 0, 16'h0077, 16'h0000, 32'd61,  1));
    vecs.push_back(mk(0, 0, 0, 16'h8000, 32'd70,  0, 0, 16'h0000, 16'h0000, 32'd0,   0));
    vecs.push_back(mk(0, 0, 1, 16'h1111, 32'd71,  0, 0, 16'h0000, 16'h0000, 32'd0,   0));
    vecs.push_back(mk(0, 0, 0, 16'h0005, 32'd72,  1, 0, 16'h0005, 16'h0000, 32'd72,  1));
    vecs.push_back(mk(0, 0, 0, 16'h8123, 32'd80,  0, 0, 16'h0000, 16'h0000, 32'd0,   0));
    vecs.push_back(mk(0, 1, 1, 16'h2222, 32'd81,  0, 0, 16'h0000, 16'h0000, 32'd0,   0));
    vecs.push_back(mk(0, 0, 0, 16'h0006, 32'd82,  1, 0, 16'h0006, 16'h0000, 32'd82,  1));
    vecs.push_back(mk(0, 0, 0, 16'h8456, 32'd90,  0, 0, 16'h0000, 16'h0000, 32'd0,   0));
    vecs.push_back(mk(1, 0, 0, 16'h3333, 32'd91,  0, 0, 16'h0000, 16'h0000, 32'd0,   1));
    vecs.push_back(mk(0, 0, 0, 16'h0007, 32'd92,  1, 0, 16'h0007, 16'h0000, 32'd92,  1));
    vecs.push_back(mk(0, 0, 0, 16'h8001, 32'd100, 0, 0, 16'h0000, 16'h0000, 32'd0,   0));
    vecs.push_back(mk(0, 0, 0, 16'hFFFF, 32'd101, 1, 1, 16'h8001, 16'hFFFF, 32'd100, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0009, 32'd102, 1, 0, 16'h0009, 16'h0000, 32'd102, 1));
    vecs.push_back(mk(0, 0, 0, 16'h8002, 32'd110, 0, 0, 16'h0000, 16'h0000, 32'd0,   0));
    vecs.push_back(mk(0, 0, 0, 16'h1111, 32'd111, 1, 1, 16'h8002, 16'h1111, 32'd110, 1));
    vecs.push_back(mk(0, 0, 0, 16'h8003, 32'd112, 0, 0, 16'h0000, 16'h0000, 32'd0,   0));
    vecs.push_back(mk(0, 0, 0, 16'h2222, 32'd113, 1, 1, 16'h8003, 16'h2222, 32'd112, 1));
    vecs.push_back(mk(0, 0, 0, 16'h8004, 32'd120, 0, 0, 16'h0000, 16'h0000, 32'd0,   0));
    vecs.push_back(mk(0, 1, 0, 16'h5555, 32'd121, 0, 0, 16'h0000, 16'h0000, 32'd0,   0));
    vecs.push_back(mk(0, 0, 0, 16'h5555, 32'd121, 1, 1, 16'h8004, 16'h5555, 32'd120, 1));
    vecs.push_back(mk(0, 0, 0, 16'h000A, 32'd122, 1, 0, 16'h000A, 16'h0000, 32'd122, 1));

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      v.id = i;
      reset       = v.rst;
      stall       = v.stl;
      flush       = v.fls;
      instruction = v.ins;
      pc_in       = v.pc;
      @(posedge clk);
      exp_q.push_back(v);
      #1;
    end
    reset = 1'b0; stall = 1'b1; flush = 1'b0;

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected packets left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
